// File: rtl/reg_writeback.sv
// Register-file writeback: round-robin ex/mem arbiter, 2-entry in-order FIFO, registered write port.
// Optional macro WB_LOAD_EXT_EN enables load lane-select and sign/zero extension on the mem channel.
module reg_writeback (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [4:0]  ex_waddr,
    input  logic [31:0] ex_wdata,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_waddr,
    input  logic [31:0] mem_wdata,
    input  logic [2:0]  mem_funct3,
    input  logic [1:0]  mem_off,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic        busy,
    output logic [1:0]  pend_cnt
);

    logic [4:0]  r_fifo_addr [2];
    logic [31:0] r_fifo_data [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_cnt;
    logic        r_rr_mem;
    logic        r_we;
    logic [4:0]  r_waddr;
    logic [31:0] r_wdata;

    logic        w_pop;
    logic        w_space;
    logic        w_grant_mem;
    logic        w_grant_ex;
    logic        w_accept;
    logic        w_push;
    logic [4:0]  w_in_addr;
    logic [31:0] w_in_data;
    logic [31:0] w_mem_data;

`ifdef WB_LOAD_EXT_EN
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (mem_off)
            2'd0:    w_byte = mem_wdata[7:0];
            2'd1:    w_byte = mem_wdata[15:8];
            2'd2:    w_byte = mem_wdata[23:16];
            default: w_byte = mem_wdata[31:24];
        endcase
        w_half = mem_off[1] ? mem_wdata[31:16] : mem_wdata[15:0];
        case (mem_funct3)
            3'b000:  w_mem_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_mem_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_mem_data = {24'd0, w_byte};
            3'b101:  w_mem_data = {16'd0, w_half};
            default: w_mem_data = mem_wdata;
        endcase
    end
`else
    logic w_unused;

    assign w_mem_data = mem_wdata;
    assign w_unused   = ^{mem_funct3, mem_off};
`endif

    // With rdy high a non-empty FIFO always pops, so a slot is free whenever rdy is high.
    assign w_pop       = rdy & (r_cnt != 2'd0);
    assign w_space     = (r_cnt != 2'd2) | w_pop;
    assign w_grant_mem = mem_valid & (~ex_valid | r_rr_mem);
    assign w_grant_ex  = ex_valid & ~w_grant_mem;

    assign ex_ready  = ~rst & rdy & w_grant_ex & w_space;
    assign mem_ready = ~rst & rdy & w_grant_mem & w_space;

    assign w_accept  = (ex_valid & ex_ready) | (mem_valid & mem_ready);
    assign w_in_addr = w_grant_mem ? mem_waddr : ex_waddr;
    assign w_in_data = w_grant_mem ? w_mem_data : ex_wdata;
    // Writes to x0 are accepted but never enqueued.
    assign w_push    = w_accept & (w_in_addr != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_addr[i] <= 5'd0;
                r_fifo_data[i] <= 32'd0;
            end
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_cnt    <= 2'd0;
            r_rr_mem <= 1'b1;
        end else begin
            if (w_push) begin
                r_fifo_addr[r_wr_ptr] <= w_in_addr;
                r_fifo_data[r_wr_ptr] <= w_in_data;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
            if (rdy & ex_valid & mem_valid) begin
                r_rr_mem <= ~w_grant_mem;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_waddr <= 5'd0;
            r_wdata <= 32'd0;
        end else if (rdy) begin
            if (r_cnt != 2'd0) begin
                r_we    <= 1'b1;
                r_waddr <= r_fifo_addr[r_rd_ptr];
                r_wdata <= r_fifo_data[r_rd_ptr];
            end else begin
                r_we <= 1'b0;
            end
        end
    end

    assign we       = r_we;
    assign waddr    = r_waddr;
    assign wdata    = r_wdata;
    assign pend_cnt = r_cnt;
    assign busy     = (r_cnt != 2'd0) | r_we;

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: rdy  in  1  global run enable; low = pause.
REQ-004 SHALL have ports: ex_valid in 1, ex_ready out 1, ex_waddr in 5, ex_wdata in 32  (execute-result channel).
REQ-005 SHALL have ports: mem_valid in 1, mem_ready out 1, mem_waddr in 5, mem_wdata in 32, mem_funct3 in 3, mem_off in 2  (load-result channel).
REQ-006 SHALL have ports: we out 1, waddr out 5, wdata out 32  (register-file write port).
REQ-007 SHALL have ports: busy out 1 (FIFO or output stage occupied), pend_cnt out 2 (FIFO occupancy 0..2).

Function
REQ-008 SHALL buffer results in a 2-entry in-order FIFO of {addr[4:0], data[31:0]} feeding a registered output stage (we/waddr/wdata).
REQ-009 SHALL accept at most one result per cycle; a transfer occurs when valid & ready are high at a rising edge with rdy high.
REQ-010 SHALL assert a channel's ready only when rdy=1, that channel is granted, and (pend_cnt<2 or a pop occurs in the same cycle).
REQ-011 SHALL grant the only requesting channel; when both are valid, grant the channel not granted at the last contested cycle (1-bit round-robin, reset pointing to mem first).
REQ-012 SHALL, on each rdy-high edge with FIFO non-empty, pop the head into the output stage with we=1; with FIFO empty, load we=0 (waddr/wdata hold).
REQ-013 SHALL give fixed latency: result accepted at edge k -> we=1 with that data during cycle k+1..k+2, written by the register file at edge k+2 (when FIFO was empty).
REQ-014 SHALL accept results with waddr=0 (ready per REQ-010) but discard them; we SHALL never be 1 with waddr=0.
REQ-015 SHALL, while rdy=0, freeze FIFO, arbitration pointer and output stage (we holds its value); the pending write completes at the first edge with rdy=1.
REQ-016 SHALL support simultaneous push and pop at full FIFO (pend_cnt stays 2).
REQ-017 SHALL preserve acceptance order for writes to the same register (later accept wins).
REQ-018 SHALL drive busy = (pend_cnt!=0) | we.

Reset
REQ-019 SHALL on rst=1 immediately (asynchronously) clear FIFO (pend_cnt=0), we=0, waddr=0, wdata=0, round-robin pointer=mem.
REQ-020 SHALL drop any in-flight or buffered result on reset mid-operation; no write issued after reset release until a new accept.
REQ-021 SHALL hold ex_ready=mem_ready=0 while rst=1.

Configuration
REQ-022 SHALL honour macro WB_LOAD_EXT_EN: when defined, mem_wdata SHALL be lane-selected by mem_off and extended per mem_funct3 before enqueue: 000 LB sign-extend byte, 001 LH sign-extend half (mem_off[1] selects half), 010 LW raw, 100 LBU zero-extend byte, 101 LHU zero-extend half, other codes raw.
REQ-023 SHALL, when WB_LOAD_EXT_EN is undefined, enqueue mem_wdata unmodified and ignore mem_funct3/mem_off; timing identical in both builds.

Verification
REQ-024 SHALL cover: ex_valid=1, ex_waddr=5, ex_wdata=0x1234_5678 for one cycle, FIFO empty -> we=1, waddr=5, wdata=0x12345678 exactly one cycle, two edges after accept.
REQ-025 SHALL cover: ex and mem both valid every cycle (waddr 1 and 2) -> accepts alternate mem,ex,mem,ex; pend_cnt never exceeds 2; no result lost or duplicated.
REQ-026 SHALL cover: ex_waddr=0, data 0xFFFF_FFFF -> ex_ready=1, we stays 0, pend_cnt stays 0.
REQ-027 SHALL cover: we=1 (waddr=3) then rdy=0 for 4 cycles -> we, waddr, pend_cnt frozen, readies 0; rdy=1 -> write completes next edge, then we=0.
REQ-028 SHALL cover (WB_LOAD_EXT_EN defined): mem_wdata=0x80FF_7F80, funct3=000, off=1 -> wdata=0x0000_007F; funct3=001, off=2 -> 0xFFFF_80FF; funct3=101, off=2 -> 0x0000_80FF; undefined -> 0x80FF7F80.
REQ-029 SHALL cover: FIFO full, rst pulsed asynchronously mid-cycle -> we=0, pend_cnt=0 immediately; no write after release without new input.
